// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB requester: command in, APB transfer out, single-cycle response back
`timescale 1ns/1ps

package apb_pkg;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
endpackage

module apb_requester
   import apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_strb,
   input  logic [2:0]            cmd_prot,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic [STRB_WIDTH-1:0] pstrb,
   output logic [2:0]            pprot,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // The abort fires on the TIMEOUT-th low-pready ACCESS cycle, i.e. when the
   // counter of already-elapsed wait cycles equals TIMEOUT-1.
   localparam logic [5:0] WAIT_LAST = 6'(TIMEOUT - 1);

   state_t     state;
   state_t     next_state;
   logic [5:0] wait_cnt;
   logic       accept;
   logic       complete;
   logic       abort;

   // Handshake and transfer-termination decode
   always_comb begin
      accept   = cmd_valid && cmd_ready;
      complete = (state == ACCESS) && pready;
      abort    = (state == ACCESS) && !pready && (wait_cnt == WAIT_LAST);
   end

   // State register
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) next_state = SETUP;
         end
         SETUP: begin
            next_state = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               next_state = accept ? SETUP : IDLE;
            end else if (abort) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // APB control and command handshake outputs decoded from the state
   always_comb begin
      psel      = 1'b0;
      penable   = 1'b0;
      cmd_ready = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
         end
         SETUP: begin
            psel = 1'b1;
         end
         ACCESS: begin
            psel      = 1'b1;
            penable   = 1'b1;
            cmd_ready = pready;
         end
         default: begin
            psel = 1'b0;
         end
      endcase
   end

   // Wait counter: cleared as a transfer enters SETUP, counts low-pready ACCESS cycles
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wait_cnt <= '0;
      end else if (next_state == SETUP) begin
         wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
         wait_cnt <= wait_cnt + 6'd1;
      end
   end

   // Command capture; the APB address/data phase signals are these registers
   // directly, so they stay stable for the whole transfer and hold in IDLE
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         pwrite <= 1'b0;
         paddr  <= '0;
         pwdata <= '0;
         pstrb  <= '0;
         pprot  <= '0;
      end else if (accept) begin
         pwrite <= cmd_write;
         paddr  <= cmd_addr;
         pwdata <= cmd_wdata;
         pstrb  <= cmd_write ? cmd_strb : '0;
         pprot  <= cmd_prot;
      end
   end

   // Response pulse one cycle after completion or timeout abort
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         rsp_valid <= complete || abort;
         if (complete) begin
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= pwrite ? '0 : prdata;
         end else if (abort) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
         end
      end
   end

endmodule
